// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: issues req/ack transfers, stalls the pipeline, flags errors.
// Optional request timeout abort is compiled in with `define DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
  parameter int TO_W     = 8,
  parameter int TO_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state_r;
  logic       access_s;
  logic       misaligned_s;
  logic       conflict_r;
  logic       timeout_s;

  assign access_s     = mem_read_i | mem_write_i;
  assign misaligned_s = (addr_i[1:0] != 2'b00);

  // Pipeline freeze: pending access in IDLE, or waiting on memory
  always_comb begin
    stall_o = 1'b0;
    if (state_r == ST_REQ) begin
      stall_o = 1'b1;
    end else if (state_r == ST_IDLE) begin
      stall_o = access_s;
    end else begin
      stall_o = 1'b0;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);
  logic [TO_W-1:0] to_cnt_r;

  // Count REQ cycles without ack; the abort fires on the TO_LIMIT-th such cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_r <= '0;
    end else if (state_r == ST_REQ) begin
      if (!dmem_ack_i) begin
        to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
        to_cnt_r <= to_cnt_r;
      end
    end else begin
      to_cnt_r <= '0;
    end
  end

  assign timeout_s = (state_r == ST_REQ) && !dmem_ack_i && (to_cnt_r == TO_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // Access FSM and registered memory/MEM-WB outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= 32'h0000_0000;
      dmem_wdata_o <= 32'h0000_0000;
      rdata_o      <= 32'h0000_0000;
      err_o        <= 1'b0;
      conflict_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (access_s && misaligned_s) begin
            rdata_o <= 32'h0000_0000;
            err_o   <= 1'b1;
            state_r <= ST_DONE;
          end else if (access_s) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= mem_write_i;
            dmem_addr_o  <= {addr_i[31:2], 2'b00};
            dmem_wdata_o <= wdata_i;
            // Read+write together still performs the write but reports an error
            conflict_r   <= mem_read_i & mem_write_i;
            state_r      <= ST_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            if (!dmem_we_o) begin
              rdata_o <= dmem_rdata_i;
            end
            err_o   <= conflict_r;
            state_r <= ST_DONE;
          end else if (timeout_s) begin
            dmem_req_o <= 1'b0;
            rdata_o    <= 32'hDEAD_BEEF;
            err_o      <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_DONE: begin
          err_o   <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          dmem_req_o <= 1'b0;
          err_o      <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= 32'h0000_0000;
    end else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end else begin
      stall_cnt_o <= stall_cnt_o;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl (default build, timeout feature off).
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        err_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] model_rdata;
  logic [31:0] model_stall_cnt;

  dmem_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .rdata_o      (rdata_o),
    .stall_o      (stall_o),
    .err_o        (err_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete access; memory acks in REQ cycle number waits+1
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int waits, input logic [31:0] mem_data);
    int stall_n = 0;
    int req_n = 0;
    bit done = 1'b0;
    bit mis;
    logic exp_err;
    int exp_stall;
    int exp_req;
    mis       = (addr % 4) != 0;
    exp_err   = mis || (rd && wr);
    exp_stall = mis ? 1 : waits + 2;
    exp_req   = mis ? 0 : waits + 1;
    if (mis) model_rdata = 32'h0;
    else if (!wr) model_rdata = mem_data;
    model_stall_cnt = model_stall_cnt + exp_stall;

    @(posedge clk); #1;
    mem_read_i = rd; mem_write_i = wr; addr_i = addr; wdata_i = wd;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (stall_o) stall_n++;
      if (dmem_req_o) begin
        req_n++;
        checks++;
        if (dmem_addr_o !== (addr & 32'hFFFF_FFFC) || dmem_we_o !== wr || dmem_wdata_o !== wd) begin
          errors++;
          $display("FAIL %s req_fields: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                   name, dmem_addr_o, dmem_we_o, dmem_wdata_o, addr & 32'hFFFF_FFFC, wr, wd);
        end
        if (req_n == waits + 1) begin
          dmem_ack_i = 1'b1;
          dmem_rdata_i = mem_data;
        end
      end else if (!stall_o) begin
        done = 1'b1;
        checks++;
        if (err_o !== exp_err) begin
          errors++;
          $display("FAIL %s err: got %b required %b", name, err_o, exp_err);
        end
        checks++;
        if (rdata_o !== model_rdata) begin
          errors++;
          $display("FAIL %s rdata: got %h required %h", name, rdata_o, model_rdata);
        end
        checks++;
        if (stall_cnt_o !== model_stall_cnt) begin
          errors++;
          $display("FAIL %s stall_cnt: got %0d required %0d", name, stall_cnt_o, model_stall_cnt);
        end
        mem_read_i = 1'b0; mem_write_i = 1'b0;
      end
      @(posedge clk); #1;
      dmem_ack_i = 1'b0;
      dmem_rdata_i = $urandom;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s done_timeout: no DONE within cycle budget", name);
    end
    checks++;
    if (stall_n != exp_stall || req_n != exp_req) begin
      errors++;
      $display("FAIL %s cycles: stall=%0d req=%0d required stall=%0d req=%0d",
               name, stall_n, req_n, exp_stall, exp_req);
    end
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: err=%b stall=%b required 0 0", name, err_o, stall_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    model_rdata = 32'h0; model_stall_cnt = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dmem_req_o, dmem_we_o, stall_o, err_o} !== 4'b0000 || dmem_addr_o !== 32'h0 ||
        dmem_wdata_o !== 32'h0 || rdata_o !== 32'h0 || stall_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: req=%b we=%b stall=%b err=%b addr=%h wdata=%h rdata=%h cnt=%0d required all 0",
               dmem_req_o, dmem_we_o, stall_o, err_o, dmem_addr_o, dmem_wdata_o, rdata_o, stall_cnt_o);
    end
    rst = 1'b1;
    // Stray ack while idle must do nothing
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_0000;
    @(posedge clk); #1; dmem_ack_i = 1'b0;
    @(negedge clk);
    checks++;
    if (rdata_o !== 32'h0 || err_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack: rdata=%h err=%b stall=%b required 0 0 0", rdata_o, err_o, stall_o);
    end
  endtask

  task automatic test_directed();
    run_access("aligned_load", 1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, 32'h1234_5678);
    run_access("store_4ws", 1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4, 32'h5555_AAAA);
    run_access("misaligned_load", 1'b1, 1'b0, 32'h0000_0102, 32'h0, 0, 32'h1111_2222);
    run_access("rw_conflict", 1'b1, 1'b1, 32'h0000_0300, 32'h0BAD_C0DE, 1, 32'h7777_8888);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [1:0] op;
      logic [31:0] a;
      op = 2'($urandom_range(1, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_access("random", op[0], op[1], a, $urandom, $urandom_range(0, 5), $urandom);
    end
  endtask

  task automatic test_long_wait();
    // No abort in the default build: request survives well past TO_LIMIT
    run_access("long_wait", 1'b1, 1'b0, 32'h0000_0400, 32'h0, 300, 32'h0F0F_0F0F);
  endtask

  task automatic test_reset_mid_req();
    @(posedge clk); #1;
    mem_read_i = 1'b1; addr_i = 32'h0000_0500;
    repeat (3) @(posedge clk);  // IDLE, REQ ws0, REQ ws1 -> now in wait state 2
    @(negedge clk);
    rst = 1'b0; mem_read_i = 1'b0;
    model_rdata = 32'h0; model_stall_cnt = 32'h0;
    #1;
    checks++;
    if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || stall_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_req: req=%b stall=%b cnt=%0d required 0 0 0", dmem_req_o, stall_o, stall_cnt_o);
    end
    @(negedge clk); rst = 1'b1;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hABCD_EF01;
    @(posedge clk); #1; dmem_ack_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (err_o !== 1'b0 || rdata_o !== model_rdata || stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL late_ack: err=%b rdata=%h stall=%b req=%b required 0 %h 0 0",
                 err_o, rdata_o, stall_o, dmem_req_o, model_rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_access("b2b_store", 1'b0, 1'b1, 32'h0000_0600, 32'h1357_9BDF, 0, 32'h0);
    run_access("b2b_load", 1'b1, 1'b0, 32'h0000_0604, 32'h0, 2, 32'h2468_ACE0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_long_wait();
    test_reset_mid_req();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the 5-stage MIPS pipeline.
- Takes the MemRead/MemWrite controls, ALU address and store data from the EX/MEM pipeline register. Drives a variable-latency req/ack data-memory port.
- Freezes the pipeline (PC, IF/ID, ID/EX, EX/MEM) with stall_o until the access completes, then presents load data to MEM/WB.
- Also flags misaligned accesses and counts stall cycles.

Parameters:
- TO_W, 8, width of the request-timeout counter (used only with DMEM_TIMEOUT_EN).
- TO_LIMIT, 255, REQ-state cycles before timeout abort; must satisfy 1 <= TO_LIMIT <= 2^TO_W-1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- mem_read_i  in  1  MemRead from EX/MEM
- mem_write_i  in  1  MemWrite from EX/MEM
- addr_i  in  32  ALU result from EX/MEM (byte address)
- wdata_i  in  32  store data from EX/MEM
- dmem_req_o  out  1  memory request, registered
- dmem_we_o  out  1  1=write, 0=read; valid while dmem_req_o=1
- dmem_addr_o  out  32  word address, registered
- dmem_wdata_o  out  32  store data, registered
- dmem_ack_i  in  1  memory completion, single-cycle pulse
- dmem_rdata_i  in  32  read data, valid when dmem_ack_i=1
- rdata_o  out  32  load result to MEM/WB, registered
- stall_o  out  1  freeze pipeline registers and PC
- err_o  out  1  access error, held for the DONE cycle
- stall_cnt_o  out  32  saturating count of stall_o-high cycles

Behaviour:
- Reset (async, rst=0):
  - state=IDLE.
  - dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0.
  - rdata_o=0, err_o=0, stall_cnt_o=0.
  - stall_o=0 (combinational, from state=IDLE and inputs).
  - Reset mid-access drops the request at once. No completion is produced. A later ack is ignored.
- access = mem_read_i | mem_write_i.
- Misaligned: addr_i[1:0] != 0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - access=0: stay IDLE.
  - access=1 and aligned: at the edge, latch dmem_addr_o = {addr_i[31:2],2'b00}, dmem_wdata_o = wdata_i, dmem_we_o = mem_write_i; set dmem_req_o=1; go to REQ.
  - access=1 and misaligned: no memory request; rdata_o <= 0; err_o <= 1; go to DONE.
- REQ:
  - dmem_req_o, addr, we and wdata are held stable until ack.
  - On dmem_ack_i=1: dmem_req_o <= 0; if read, rdata_o <= dmem_rdata_i; if write, rdata_o is unchanged; go to DONE.
- DONE: lasts one cycle; stall_o=0 so the pipeline advances this edge; err_o is cleared at exit; go to IDLE.
- stall_o = (state==IDLE & access) | (state==REQ). Combinational.
- Minimum access latency: 3 cycles (IDLE detect, REQ with same-cycle ack, DONE). Stall is high for the first 2 cycles.
- Read and write asserted together: write wins (dmem_we_o=1), err_o=1 in DONE, the memory write is still performed.
- dmem_ack_i outside REQ is ignored.
- The EX/MEM inputs are assumed stable while stall_o=1; the pipeline freezes them.
- stall_cnt_o increments on each edge where stall_o=1 and saturates at 32'hFFFFFFFF.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on entering REQ and increments each REQ cycle without ack.
  - When it reaches TO_LIMIT without ack: dmem_req_o <= 0, rdata_o <= 32'hDEADBEEF, err_o <= 1, go to DONE.
  - Ack in the same cycle as the limit: ack wins, normal completion.
- Not defined: REQ waits indefinitely; no counter logic is synthesised.

Test Plan:
- Reset, then aligned load: mem_read_i=1, addr_i=0x0000_0104; memory acks in the first REQ cycle with 0x1234_5678. Expect dmem_addr_o=0x104, dmem_we_o=0, stall_o high 2 cycles, rdata_o=0x1234_5678 in DONE, stall_cnt_o=2.
- Store with 4 wait states: mem_write_i=1, addr_i=0x200, wdata_i=0xCAFE_F00D. Expect dmem_req_o held 5 cycles with stable addr/data, dmem_we_o=1, stall_o high 6 cycles, err_o=0.
- Misaligned load, addr_i=0x0000_0102. Expect dmem_req_o never asserted, stall_o high 1 cycle, DONE with err_o=1 and rdata_o=0.
- mem_read_i=mem_write_i=1 at 0x300. Expect a write request (dmem_we_o=1), and err_o=1 in DONE.
- Assert rst low during REQ (wait state 2). Expect dmem_req_o=0 and stall_o=0 immediately. A later ack produces no DONE and no rdata_o change.
- With DMEM_TIMEOUT_EN and TO_LIMIT=4, no ack. Expect dmem_req_o to drop after 4 REQ cycles, rdata_o=0xDEADBEEF, err_o=1. Without the macro, stall_o stays high indefinitely.
